// File: rtl/calc_pkg.sv
// Shared widths and FSM encoding for the calculator datapath.
// The multiplier, divider and LED mux all size themselves from here.
package calc_pkg;

  localparam int OPW_DEF = 4;
  localparam int RW_DEF  = 2 * OPW_DEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Takes OPW CALC cycles per product; accepts back-to-back starts from DONE.
module shift_add_multiplier
  import calc_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPW-1:0]    a,
  input  logic [OPW-1:0]    b,
  output logic [2*OPW-1:0]  product,
  output logic              busy,
  output logic              done
);

  localparam int RW = 2 * OPW;
  localparam int CW = $clog2(OPW + 1);

  state_e          state_q;
  logic [RW-1:0]   mcand_q;
  logic [OPW-1:0]  mplier_q;
  logic [RW-1:0]   acc_q;
  logic [RW-1:0]   acc_d;
  logic [RW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            last_c;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign last_c = (cnt_q == CW'(OPW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            mcand_q  <= RW'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Fixed OPW steps: result lands in product on the DONE-entry edge.
          if (last_c) begin
            state_q <= S_DONE;
            prod_q  <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign product = prod_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (OPW=4).
// Stimulus pushes expected products; a negedge monitor pops on done.
module tb_shift_add_multiplier;

  localparam int OPW = 4;
  localparam int RW  = 2 * OPW;

  logic           clk;
  logic           rst;
  logic           start;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic [RW-1:0]  product;
  logic           busy;
  logic           done;

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] exp_q[$];
  int  cyc       = 0;
  int  last_done = -1;
  bit  sp_en     = 1'b0;

  shift_add_multiplier #(.OPW(OPW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .product(product),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: scoreboard compare, busy/done exclusivity, done spacing.
  always @(negedge clk) begin
    cyc++;
    if (done && busy) begin
      checks++;
      failures++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", busy, done);
    end
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: product=%0d with empty scoreboard", product);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          failures++;
          $display("FAIL product: got %0d expected %0d", product, e);
        end
      end
      if (sp_en && last_done >= 0) begin
        checks++;
        if (cyc - last_done != OPW + 1) begin
          failures++;
          $display("FAIL done_spacing: got %0d expected %0d", cyc - last_done, OPW + 1);
        end
      end
      last_done = cyc;
    end
  end

  task automatic issue(input int av, input int bv, input int ev);
    a     = OPW'(av);
    b     = OPW'(bv);
    start = 1'b1;
    exp_q.push_back(RW'(ev));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges from the accept edge to done; returns 0 on timeout.
  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  int lat, nb, extra;
  int vec_a [4] = '{15, 0, 9, 3};
  int vec_b [4] = '{15, 9, 0, 5};
  int vec_p [4] = '{225, 0, 0, 15};

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_product", int'(product), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: 15*15, 0*9, 9*0
    for (int v = 0; v < 3; v++) begin
      issue(vec_a[v], vec_b[v], vec_p[v]);
      wait_done(lat, nb);
      chk("latency", lat, OPW + 1);
      chk("busy_cycles", nb, OPW);
      @(negedge clk);
      chk("done_pulse", int'(done), 0);
      chk("product_hold", int'(product), vec_p[v]);
    end

    // 6*7 with start held through CALC and operands changed mid-flight
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    exp_q.push_back(RW'(42));
    @(posedge clk);
    #1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 4'd1;
        b = 4'd1;
      end
      if (i <= OPW) chk("product_stable_calc", int'(product), 0);
      if (done) begin
        lat = i;
        start = 1'b0;
        break;
      end
    end
    chk("held_start_latency", lat, OPW + 1);
    count_done(8, extra);
    chk("held_start_single_done", extra, 0);

    // 3*5 then 2*4 issued during the DONE cycle
    issue(3, 5, 15);
    wait_done(lat, nb);
    chk("b2b_first_latency", lat, OPW + 1);
    issue(2, 4, 8);
    wait_done(lat, nb);
    chk("b2b_second_latency", lat, OPW + 1);
    @(negedge clk);

    // 12*11 aborted by reset on the 2nd busy cycle
    a = 4'd12;
    b = 4'd11;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    count_done(10, extra);
    chk("abort_no_done", extra, 0);

    // Exhaustive back-to-back sweep
    sp_en     = 1'b1;
    last_done = -1;
    issue(0, 0, 0);
    for (int p = 0; p < 256; p++) begin
      wait_done(lat, nb);
      chk("sweep_latency", lat, OPW + 1);
      if (lat == 0) break;
      if (p < 255)
        issue((p + 1) / 16, (p + 1) % 16, ((p + 1) / 16) * ((p + 1) % 16));
    end
    sp_en = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: OPW, default 4, operand width in bits; the result is 2*OPW bits wide.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE or DONE.
REQ-005 a  input  OPW  multiplicand (unsigned); captured on the accepted start edge.
REQ-006 b  input  OPW  multiplier (unsigned); captured on the accepted start edge.
REQ-007 product  output  2*OPW  registered result; holds the last completed value.
REQ-008 busy  output  1  high while the operation is in CALC.
REQ-009 done  output  1  one-cycle pulse; product is valid and newly updated in that cycle.

Function
REQ-010 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-011 IDLE: start=1 SHALL latch a into the multiplicand register (zero-extended to 2*OPW) and b into the multiplier shift register, clear the accumulator and step counter, and move to CALC.
REQ-012 CALC: each cycle, if the multiplier LSB is 1 the accumulator SHALL add the multiplicand; the multiplicand then shifts left 1, the multiplier shifts right 1, and the counter increments.
REQ-013 CALC SHALL last exactly OPW cycles regardless of operand values; there is no early-out on zero.
REQ-014 On the final CALC cycle, the state SHALL move to DONE and product SHALL load the final accumulator value on the same edge.
REQ-015 Latency: a start accepted at edge k SHALL give busy=1 in cycles k+1..k+OPW and done=1 in cycle k+OPW+1; for OPW=4, done is high 5 cycles after start.
REQ-016 DONE: done=1 and busy=0; start=1 SHALL be accepted exactly as in IDLE (back-to-back), otherwise the next state is IDLE.
REQ-017 start SHALL be ignored while in CALC; the in-flight operands and counter are unaffected.
REQ-018 a and b SHALL be ignored outside the accepted start edge; changing them during CALC SHALL NOT alter the result.
REQ-019 product SHALL change only on the DONE-entry edge or on reset, and SHALL keep the previous result during CALC.
REQ-020 Arithmetic SHALL be unsigned with a 2*OPW-bit accumulator; overflow is impossible (max (2^OPW-1)^2 fits).
REQ-021 done and busy SHALL never be high in the same cycle.

Reset
REQ-022 rst=1 SHALL force state IDLE and clear product, busy, done, the accumulator, the shift registers and the counter to 0 on the next edge.
REQ-023 rst asserted mid-CALC SHALL abort the operation; no done pulse follows and product reads 0.
REQ-024 rst SHALL take priority over start in the same cycle.

Structure
REQ-025 A shared package calc_pkg SHALL hold the OPW default (4), the derived result width and the FSM state encoding, so the divider and the LED mux use the same widths.
REQ-026 The block SHALL be a single module with no sub-modules; the datapath is one add/shift step, so no separate instance is warranted.
REQ-027 The LED select logic SHALL be able to use product in place of a combinational multiply, with done as the update strobe.

Verification
REQ-028 a=15, b=15, start pulse -> done exactly 5 cycles later, product=225 (0xE1), busy high for 4 cycles.
REQ-029 a=0, b=9 and a=9, b=0 -> product=0, still 4 busy cycles and then done.
REQ-030 a=6, b=7, start held high through CALC, and a/b changed to 1/1 at cycle 2 -> product=42, only one done pulse.
REQ-031 a=3, b=5, start asserted again during the DONE cycle with a=2, b=4 -> first done gives product=15; the second done 5 cycles later gives product=8.
REQ-032 a=12, b=11, rst asserted at the 2nd busy cycle -> next cycle busy=0, done=0, product=0; no done pulse afterwards.
REQ-033 Exhaustive OPW=4 sweep of all 256 a/b pairs, back-to-back -> every product equals a*b and every done is spaced exactly 5 cycles apart.
